// File: rtl/matrix_ls_responder.sv
// matrix_ls_responder: load/store operand buffer holding one ROWS x COLS matrix
module matrix_ls_responder #(
  parameter int DWIDTH = 16,
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        op_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DWIDTH-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DWIDTH-1:0] out_data_o,
  output logic              out_last_o,
  output logic              done_o,
  output logic              err_o,
  output logic              loaded_o
);
  localparam int N = ROWS * COLS;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, nxt;
  logic [DWIDTH-1:0] mem [N];
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic done_q, done_d, err_q, err_d, loaded_q, loaded_d, mem_we;
  assign op_ready_o = state_q == IDLE;
  assign in_ready_o = state_q == LOAD;
  assign out_valid_o = out_valid_q;
  assign out_data_o = out_data_q;
  assign out_last_o = out_last_q;
  assign done_o = done_q;
  assign err_o = err_q;
  assign loaded_o = loaded_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    nxt = idx_q + 1'b1;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    done_d = 1'b0;
    err_d = 1'b0;
    loaded_d = loaded_q;
    mem_we = 1'b0;
    case (state_q)
      IDLE: if (op_valid_i) begin
        if (op_i == 2'b01) begin
          state_d = LOAD;
          idx_d = '0;
          loaded_d = 1'b0;
        end else if (op_i == 2'b10 && loaded_q) begin
          state_d = STORE;
          idx_d = '0;
          out_valid_d = 1'b1;
          out_data_d = mem[0];
          out_last_d = N == 1;
        end else if (op_i != 2'b00) begin
          err_d = 1'b1;
        end
      end
      LOAD: if (in_valid_i) begin
        mem_we = 1'b1;
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d = '0;
          done_d = 1'b1;
          loaded_d = 1'b1;
        end else begin
          idx_d = nxt;
        end
      end
      STORE: if (out_ready_i) begin
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d = '0;
          out_valid_d = 1'b0;
          out_last_d = 1'b0;
          done_d = 1'b1;
        end else begin
          idx_d = nxt;
          out_data_d = mem[nxt];
          out_last_d = nxt == LAST;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      done_q <= done_d;
      err_q <= err_d;
      loaded_q <= loaded_d;
    end
  end
  // storage is deliberately left uncleared by reset
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[idx_q] <= in_data_i;
  end
endmodule

// File: tb/tb_matrix_ls_responder.sv
// tb_matrix_ls_responder: randomized scoreboard bench for matrix_ls_responder
module tb_matrix_ls_responder;
  localparam int DW = 16;
  localparam int R = 4;
  localparam int C = 4;
  localparam int N = R * C;
  logic clk, rst;
  logic [1:0] op_i;
  logic op_valid_i, op_ready_o, in_valid_i, in_ready_o;
  logic [DW-1:0] in_data_i, out_data_o;
  logic out_valid_o, out_ready_i, out_last_o, done_o, err_o, loaded_o;
  matrix_ls_responder #(.DWIDTH(DW), .ROWS(R), .COLS(C)) dut (
    .clk(clk), .rst(rst), .op_i(op_i), .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .done_o(done_o), .err_o(err_o), .loaded_o(loaded_o)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  typedef struct packed {logic [DW-1:0] d; logic l;} exp_t;
  exp_t exp_q[$];
  exp_t e_mon;
  logic [DW-1:0] mem_m [N];
  bit loaded_m = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  bit stall_p = 0;
  logic [DW-1:0] held_d;
  logic held_l;
  always @(negedge clk) begin
    if (rst || !out_valid_o) stall_p = 0;
    else begin
      if (stall_p) begin
        check("hold_data", out_data_o, held_d);
        check("hold_last", out_last_o, held_l);
      end
      if (out_ready_i) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e_mon = exp_q.pop_front();
          check("out_data", out_data_o, e_mon.d);
          check("out_last", out_last_o, e_mon.l);
        end
        stall_p = 0;
      end else begin
        stall_p = 1;
        held_d = out_data_o;
        held_l = out_last_o;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cmd(input logic [1:0] op);
    bit e;
    check("op_ready_idle", op_ready_o, 1);
    op_i = op;
    op_valid_i = 1;
    tick();
    op_valid_i = 0;
    op_i = 0;
    e = (op == 2'b11) || (op == 2'b10 && !loaded_m);
    check("err_pulse", err_o, e);
    check("done_after_cmd", done_o, 0);
    if (op == 2'b00 || e) begin
      check("stay_idle", op_ready_o, 1);
      check("no_out_valid", out_valid_o, 0);
    end
    if (op == 2'b10 && loaded_m)
      for (int i = 0; i < N; i++) begin
        exp_t x;
        x.d = mem_m[i];
        x.l = (i == N - 1);
        exp_q.push_back(x);
      end
  endtask
  task automatic load(input bit rnd, input int upto, input bit poke);
    bit v;
    logic [DW-1:0] d;
    cmd(2'b01);
    loaded_m = 0;
    check("loaded_clear", loaded_o, 0);
    for (int i = 0; i < upto;) begin
      v = rnd ? ($urandom_range(3) != 0) : 1'b1;
      d = rnd ? DW'($urandom) : DW'(i + 1);
      in_valid_i = v;
      in_data_i = d;
      check("in_ready", in_ready_o, 1);
      if (poke && i < 3) begin
        op_valid_i = 1;
        op_i = 2'b11;
        check("op_ready_busy", op_ready_o, 0);
      end
      tick();
      op_valid_i = 0;
      op_i = 0;
      if (poke) check("no_err_busy", err_o, 0);
      if (v) begin
        mem_m[i] = d;
        i++;
      end
    end
    in_valid_i = 0;
    if (upto == N) begin
      loaded_m = 1;
      check("load_done", done_o, 1);
      check("load_loaded", loaded_o, 1);
      check("load_in_ready_off", in_ready_o, 0);
      check("load_idle", op_ready_o, 1);
    end
  endtask
  task automatic store(input int mode);
    int cyc = 0;
    bit was_loaded = loaded_m;
    cmd(2'b10);
    if (!was_loaded) return;
    check("out_valid_start", out_valid_o, 1);
    while (!done_o && cyc < 20 * N) begin
      out_ready_i = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(1));
      tick();
      cyc++;
    end
    out_ready_i = 0;
    check("store_done", done_o, 1);
    if (mode == 0) check("store_cycles", cyc, N);
    check("store_valid_off", out_valid_o, 0);
    check("store_last_off", out_last_o, 0);
    check("store_drained", exp_q.size(), 0);
    check("store_loaded", loaded_o, 1);
  endtask
  initial begin
    rst = 1;
    op_i = 0;
    op_valid_i = 0;
    in_valid_i = 0;
    in_data_i = 0;
    out_ready_i = 0;
    tick();
    tick();
    check("rst_op_ready", op_ready_o, 1);
    check("rst_in_ready", in_ready_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_data", out_data_o, 0);
    check("rst_out_last", out_last_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_loaded", loaded_o, 0);
    rst = 0;
    tick();
    store(0);
    check("unloaded_store", loaded_o, 0);
    load(0, N, 0);
    store(0);
    store(1);
    store(0);
    cmd(2'b11);
    cmd(2'b00);
    check("nop_loaded", loaded_o, 1);
    load(1, N, 1);
    store(2);
    load(0, 5, 0);
    rst = 1;
    tick();
    rst = 0;
    loaded_m = 0;
    check("midrst_loaded", loaded_o, 0);
    check("midrst_in_ready", in_ready_o, 0);
    check("midrst_op_ready", op_ready_o, 1);
    store(0);
    load(0, N, 0);
    store(0);
    repeat (4) begin
      load(1, N, 1'($urandom_range(1)));
      repeat ($urandom_range(1, 2)) store($urandom_range(2));
      cmd($urandom_range(1) ? 2'b11 : 2'b00);
    end
    repeat (2) tick();
    check("final_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matrix_ls_responder.md
Name: matrix_ls_responder

Overview:
- Responder end of the matrix load/store interface: holds one ROWS x COLS matrix of DWIDTH-bit elements and serves the load/store command stream.
- Op encoding: 2'b00 nop, 2'b01 load, 2'b10 store, 2'b11 reserved/illegal.
- Load streams elements into local storage; store streams them back out, both row-major.
- Sits between the matrix command driver and the multiplier datapath as its operand/result buffer.

Parameters:
DWIDTH, 16, element width; matches the multiplier input width.
ROWS, 4, matrix rows (>=1).
COLS, 4, matrix columns (>=1).

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
op_i  in  2  command: 00 nop, 01 load, 10 store, 11 illegal
op_valid_i  in  1  command valid
op_ready_o  out  1  command accepted when op_valid_i && op_ready_o
in_valid_i  in  1  load element valid
in_ready_o  out  1  load element ready
in_data_i  in  DWIDTH  load element
out_valid_o  out  1  store element valid
out_ready_i  in  1  store element ready
out_data_o  out  DWIDTH  store element
out_last_o  out  1  marks the final store element (index ROWS*COLS-1)
done_o  out  1  one-cycle pulse after a load or store completes
err_o  out  1  one-cycle pulse on a rejected command
loaded_o  out  1  storage holds a complete, valid matrix

Behaviour:
- Reset values: op_ready_o=1, in_ready_o=0, out_valid_o=0, out_data_o=0, out_last_o=0, done_o=0, err_o=0, loaded_o=0, state=IDLE, idx=0. Memory contents are not cleared.
- Element index idx: width $clog2(ROWS*COLS), minimum 1; range 0..ROWS*COLS-1; element (r,c) is at r*COLS+c.
- States: IDLE, LOAD, STORE. op_ready_o = (state==IDLE).
- IDLE, command accepted:
  - nop: no effect.
  - load: go to LOAD, idx=0, loaded_o=0 next cycle.
  - store with loaded_o=1: go to STORE, idx=0.
  - store with loaded_o=0: err_o pulses next cycle; stay IDLE.
  - 11: err_o pulses next cycle; stay IDLE.
- LOAD:
  - in_ready_o=1.
  - Each in_valid_i && in_ready_o writes mem[idx]=in_data_i and increments idx.
  - in_valid_i low inserts a stall; there is no timeout.
  - On the handshake at idx=ROWS*COLS-1, the next cycle is IDLE with done_o=1, loaded_o=1, in_ready_o=0.
  - in_valid_i outside LOAD is ignored.
- STORE:
  - out_valid_o=1 starting the cycle after accept, out_data_o=mem[0].
  - out_data_o and out_last_o are held stable while out_valid_o && !out_ready_i.
  - Each handshake presents mem[idx+1] on the next cycle, giving back-to-back throughput of 1 element/cycle.
  - out_last_o=1 exactly while element ROWS*COLS-1 is presented.
  - After the last handshake: out_valid_o=0, out_last_o=0, done_o=1, state IDLE, all in the same next cycle.
  - loaded_o stays 1; the matrix may be stored repeatedly.
- op_valid_i outside IDLE: not accepted (op_ready_o=0). The driver must hold the command.
- Earliest next command accept is the cycle done_o is high.
- rst asserted mid-LOAD or mid-STORE: next cycle returns to reset values. The partial transfer is abandoned and loaded_o=0.
- ROWS*COLS=1: load and store each complete after one handshake; out_last_o is high on the single store element.

Test Plan:
- Reset, then store command → err_o pulses 1 cycle after accept, out_valid_o stays 0, loaded_o=0, op_ready_o=1.
- Load 0x0001..0x0010 (16 elements, in_valid_i continuous) → in_ready_o high for 16 cycles; done_o pulses the cycle after the 16th handshake; loaded_o=1.
- Store after that load with out_ready_i=1 → 16 consecutive cycles of out_data_o=0x0001..0x0010, out_last_o high only with 0x0010, done_o pulses the cycle after.
- Store with out_ready_i toggling 1,0,0,1... → data held stable during stalls; order and out_last_o unchanged; second store immediately after done_o returns the same data.
- op_i=2'b11 and op_i=nop in IDLE → 11: err_o pulse, no state change; nop: no pulse, no state change. op_valid_i during LOAD → op_ready_o=0, command not consumed.
- rst asserted after 5 load elements → loaded_o=0, in_ready_o=0 next cycle; a following store returns err_o; a fresh full load then store succeeds.
